sram_arb_ctrl: RTL and testbench

Two-port arbitration and sequencing controller for the 32-bit x 2048-word single-port OpenRAM macro (active-low `csb0`/`web0`, registered inputs, write/read on negedge). It shares the one RW port between two requesters with round-robin priority and tags read returns back to the issuing port. Optionally, it zero-fills the array after reset. It sits between the core-side masters and the SRAM macro instance.

---
 rtl/sram_arb_ctrl.sv | 136 +++++++++++++
 tb/tb_sram_arb_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arb_ctrl.sv
// Round-robin two-port arbiter and sequencer for a single-port OpenRAM macro.
// Read data is tagged back to its issuing port. The array can optionally be zero-filled after reset.
module sram_arb_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 11,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_we,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [DATA_WIDTH-1:0] p0_req_wdata,
  output logic                  p0_rsp_valid,
  output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_we,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  input  logic [DATA_WIDTH-1:0] p1_req_wdata,
  output logic                  p1_rsp_valid,
  output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  ptr_q;
  logic                  grant0, grant1, accept;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  vld_p0, vld_p1;
  logic                  port_p0, port_p1;

  // ptr_q names the port that wins when both are valid; a lone valid port always wins.
  always_comb begin
    state_d = state_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    if (state_q == ST_CLEAR) begin
      if (clr_cnt_q == LAST_ADDR) state_d = ST_RUN;
    end else begin
      grant0 = p0_req_valid && (!p1_req_valid || !ptr_q);
      grant1 = p1_req_valid && (!p0_req_valid ||  ptr_q);
    end
  end

  assign accept       = grant0 || grant1;
  assign p0_req_ready = grant0;
  assign p1_req_ready = grant1;
  assign init_done    = (state_q == ST_RUN);
  assign sel_we       = grant1 ? p1_req_we    : p0_req_we;
  assign sel_addr     = grant1 ? p1_req_addr  : p0_req_addr;
  assign sel_wdata    = grant1 ? p1_req_wdata : p0_req_wdata;

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage p0: macro pin drive (clear writes or the granted request)
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt_q  <= '0;
      ptr_q      <= 1'b0;
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
      sram_addr0 <= '0;
      sram_din0  <= '0;
      vld_p0     <= 1'b0;
      port_p0    <= 1'b0;
    end else begin
      vld_p0  <= accept && !sel_we;
      port_p0 <= grant1;
      if (state_q == ST_CLEAR) begin
        sram_csb0  <= 1'b0;
        sram_web0  <= 1'b0;
        sram_addr0 <= clr_cnt_q;
        sram_din0  <= '0;
        clr_cnt_q  <= clr_cnt_q + 1'b1;
      end else if (accept) begin
        sram_csb0  <= 1'b0;
        sram_web0  <= !sel_we;
        sram_addr0 <= sel_addr;
        sram_din0  <= sel_wdata;
        ptr_q      <= grant0;
      end else begin
        sram_csb0  <= 1'b1;
        sram_web0  <= 1'b1;
      end
    end
  end

  // Stage p1: macro has latched the pins; data appears after its negedge read
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      port_p1 <= 1'b0;
    end else begin
      vld_p1  <= vld_p0;
      port_p1 <= port_p0;
    end
  end

  // Stage p2: capture macro output into the tagged port
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      p0_rsp_valid <= 1'b0;
      p1_rsp_valid <= 1'b0;
      p0_rsp_rdata <= '0;
      p1_rsp_rdata <= '0;
    end else begin
      p0_rsp_valid <= vld_p1 && !port_p1;
      p1_rsp_valid <= vld_p1 &&  port_p1;
      if (vld_p1 && !port_p1) p0_rsp_rdata <= sram_dout0;
      if (vld_p1 &&  port_p1) p1_rsp_rdata <= sram_dout0;
    end
  end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Directed bench for sram_arb_ctrl with a behavioural OpenRAM-style macro model
// (inputs registered on posedge, access on negedge).
module tb_sram_arb_ctrl;
  localparam int DW = 32;
  localparam int AW = 11;

  logic          clk0 = 1'b0;
  logic          rst_n;
  logic          p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid;
  logic [AW-1:0] p0_req_addr;
  logic [DW-1:0] p0_req_wdata, p0_rsp_rdata;
  logic          p1_req_valid, p1_req_ready, p1_req_we, p1_rsp_valid;
  logic [AW-1:0] p1_req_addr;
  logic [DW-1:0] p1_req_wdata, p1_rsp_rdata;
  logic          init_done, sram_csb0, sram_web0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0, sram_dout0;

  always #5 clk0 = ~clk0;

  sram_arb_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk0(clk0), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
    .init_done(init_done), .sram_csb0(sram_csb0), .sram_web0(sram_web0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  // Macro model; unwritten words read back a nonzero pattern so a missing clear shows up.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  bit            written [0:(1<<AW)-1];
  logic          csb_r = 1'b1, web_r = 1'b1;
  logic [AW-1:0] addr_r = '0;
  logic [DW-1:0] din_r = '0, dout = '1;

  always @(posedge clk0) begin
    csb_r  <= sram_csb0;
    web_r  <= sram_web0;
    addr_r <= sram_addr0;
    din_r  <= sram_din0;
  end

  always @(negedge clk0) begin
    if (!csb_r) begin
      if (!web_r) begin
        mem[addr_r]     <= din_r;
        written[addr_r] <= 1'b1;
      end else begin
        dout <= written[addr_r] ? mem[addr_r] : (32'hBAD0_0000 | 32'(addr_r));
      end
    end
  end
  assign sram_dout0 = dout;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  initial begin
    int n, rdy_bad, p0_cnt, p0_at, p1_cnt, rsp_cnt;
    logic [DW-1:0] p0_dat;
    logic [1:0] expv;

    rst_n = 1'b1;
    p0_req_valid = 1'b0; p0_req_we = 1'b0; p0_req_addr = '0; p0_req_wdata = '0;
    p1_req_valid = 1'b0; p1_req_we = 1'b0; p1_req_addr = '0; p1_req_wdata = '0;
    #2 rst_n = 1'b0;
    tick();
    tick();

    // Reset state, with a request already pending on P0
    p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 11'h7FF;
    #1;
    chk("rst_csb_web", 32'({sram_csb0, sram_web0}), 32'h3);
    chk("rst_addr", 32'(sram_addr0), 32'h0);
    chk("rst_din", sram_din0, 32'h0);
    chk("rst_rsp_valid", 32'({p1_rsp_valid, p0_rsp_valid}), 32'h0);
    chk("rst_rdata0", p0_rsp_rdata, 32'h0);
    chk("rst_rdata1", p1_rsp_rdata, 32'h0);
    chk("rst_init_done", 32'(init_done), 32'h0);
    chk("rst_ready", 32'({p1_req_ready, p0_req_ready}), 32'h0);

    // Clear sequence
    rst_n = 1'b1;
    tick();
    chk("clr_first_pins", 32'({sram_csb0, sram_web0, sram_addr0}), 32'h0);
    chk("clr_first_din", sram_din0, 32'h0);
    n = 1;
    rdy_bad = 0;
    while (init_done !== 1'b1 && n < 3000) begin
      if (p0_req_ready !== 1'b0) rdy_bad++;
      tick();
      n++;
    end
    chk("clr_cycles", 32'(n), 32'd2048);
    chk("clr_ready_low", 32'(rdy_bad), 32'h0);
    chk("clr_last_addr", 32'(sram_addr0), 32'h7FF);

    // First read after clear: address 0x7FF must read zero
    chk("first_ready", 32'({p1_req_ready, p0_req_ready}), 32'h1);
    tick();
    p0_req_valid = 1'b0;
    chk("rd_pins", 32'({sram_csb0, sram_web0}), 32'h1);
    chk("rd_addr", 32'(sram_addr0), 32'h7FF);
    tick();
    chk("rd_no_early_rsp", 32'(p0_rsp_valid), 32'h0);
    tick();
    chk("rd7ff_valid", 32'(p0_rsp_valid), 32'h1);
    chk("rd7ff_data", p0_rsp_rdata, 32'h0);

    // Single-port write then read of the same address
    p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 11'h123; p0_req_wdata = 32'hDEADBEEF;
    #1;
    chk("wr_ready", 32'(p0_req_ready), 32'h1);
    tick();
    chk("wr_pins", 32'({sram_csb0, sram_web0}), 32'h0);
    chk("wr_din", sram_din0, 32'hDEADBEEF);
    chk("wr_addr", 32'(sram_addr0), 32'h123);
    p0_req_we = 1'b0;
    #1;
    chk("rd123_ready", 32'(p0_req_ready), 32'h1);
    tick();
    p0_req_valid = 1'b0;
    p0_cnt = 0; p0_at = 0; p1_cnt = 0; p0_dat = '0;
    for (int k = 2; k <= 7; k++) begin
      if (p0_rsp_valid === 1'b1) begin
        p0_cnt++;
        p0_at = k;
        p0_dat = p0_rsp_rdata;
      end
      if (p1_rsp_valid !== 1'b0) p1_cnt++;
      if (k < 7) tick();
    end
    chk("rd123_count", 32'(p0_cnt), 32'h1);
    chk("rd123_cycle", 32'(p0_at), 32'h4);
    chk("rd123_data", p0_dat, 32'hDEADBEEF);
    chk("rd123_p1_quiet", 32'(p1_cnt), 32'h0);

    // Preload for contention: P0 writes 0x010, then P1 writes 0x020
    p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 11'h010; p0_req_wdata = 32'h10101010;
    tick();
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b1; p1_req_we = 1'b1; p1_req_addr = 11'h020; p1_req_wdata = 32'h20202020;
    #1;
    chk("pre_p1_ready", 32'(p1_req_ready), 32'h1);
    tick();

    // Contention: both ports read continuously for four grants
    p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 11'h010;
    p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 11'h020;
    for (int c = 0; c <= 8; c++) begin
      if (c == 4) begin
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
      end
      #1;
      if (c < 4) chk($sformatf("cont_grant%0d", c), 32'({p1_req_ready, p0_req_ready}),
                     (c % 2 == 0) ? 32'h1 : 32'h2);
      expv = 2'b00;
      if (c >= 3 && c <= 6) expv = ((c - 3) % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("cont_rsp%0d", c), 32'({p1_rsp_valid, p0_rsp_valid}), 32'(expv));
      if (expv == 2'b01) chk($sformatf("cont_d0_%0d", c), p0_rsp_rdata, 32'h10101010);
      if (expv == 2'b10) chk($sformatf("cont_d1_%0d", c), p1_rsp_rdata, 32'h20202020);
      tick();
    end

    // Fairness: a lone P1 grant hands priority to P0
    p1_req_valid = 1'b1;
    #1;
    chk("rr_p1_alone", 32'({p1_req_ready, p0_req_ready}), 32'h2);
    tick();
    p0_req_valid = 1'b1;
    #1;
    chk("rr_next_p0", 32'({p1_req_ready, p0_req_ready}), 32'h1);
    tick();
    chk("rr_then_p1", 32'({p1_req_ready, p0_req_ready}), 32'h2);
    tick();
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    repeat (4) tick();

    // Back-to-back: P0 write, P1 read of the same word on the next cycle
    p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 11'h001; p0_req_wdata = 32'hA5A5A5A5;
    #1;
    chk("b2b_wr_ready", 32'(p0_req_ready), 32'h1);
    tick();
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 11'h001;
    #1;
    chk("b2b_rd_ready", 32'(p1_req_ready), 32'h1);
    tick();
    p1_req_valid = 1'b0;
    tick();
    chk("b2b_t3_quiet", 32'(p1_rsp_valid), 32'h0);
    tick();
    chk("b2b_t4_valid", 32'({p1_rsp_valid, p0_rsp_valid}), 32'h2);
    chk("b2b_t4_data", p1_rsp_rdata, 32'hA5A5A5A5);
    tick();

    // Reset one cycle after a read accept
    p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 11'h001;
    #1;
    chk("mid_rd_ready", 32'(p0_req_ready), 32'h1);
    tick();
    p0_req_valid = 1'b0;
    chk("mid_rd_issued", 32'(sram_csb0), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_csb_web", 32'({sram_csb0, sram_web0}), 32'h3);
    chk("mid_addr", 32'(sram_addr0), 32'h0);
    chk("mid_init_done", 32'(init_done), 32'h0);
    chk("mid_rdata0", p0_rsp_rdata, 32'h0);
    rsp_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (p0_rsp_valid !== 1'b0 || p1_rsp_valid !== 1'b0) rsp_cnt++;
    end
    rst_n = 1'b1;
    tick();
    if (p0_rsp_valid !== 1'b0 || p1_rsp_valid !== 1'b0) rsp_cnt++;
    chk("reclr_pins0", 32'({sram_csb0, sram_web0, sram_addr0}), 32'h0);
    tick();
    if (p0_rsp_valid !== 1'b0 || p1_rsp_valid !== 1'b0) rsp_cnt++;
    chk("reclr_addr1", 32'(sram_addr0), 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (p0_rsp_valid !== 1'b0 || p1_rsp_valid !== 1'b0) rsp_cnt++;
    end
    chk("mid_no_rsp", 32'(rsp_cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
